// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter slice: state encoding, header
// magic nibble, beat payload struct and header-byte helper.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned STATE_W         = 2;

  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] HDR    = 2'd1;
  localparam logic [STATE_W-1:0] STREAM = 2'd2;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  // One source beat as seen by the arbiter
  typedef struct packed {
    logic                       last;
    logic [UART_DATA_WIDTH-1:0] data;
  } beat_t;

  // Packet header: magic nibble followed by the granted source index
  function automatic logic [UART_DATA_WIDTH-1:0] hdr_byte(input logic [3:0] src);
    return {HDR_MAGIC, src};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after ptr.
module rr_pick #(
  parameter  int unsigned N_SRC = 4,
  localparam int unsigned IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_idx = '0;
    any     = |req;
    for (int unsigned k = N_SRC; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % N_SRC;
      if (req[IDX_W'(idx)]) gnt_idx = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding a single uart_tx byte stream.
// Grants are held for a whole tlast-delimited packet.
// Optional: UART_ARB_HEADER_EN prefixes each packet with {4'hA, source id}.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_SRC      = 4,
  parameter  int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  localparam int unsigned IDX_W      = $clog2(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]            s_axis_tvalid,
  input  logic [N_SRC-1:0]            s_axis_tlast,
  output logic [N_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        busy
);

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_next;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  slot_free;
  logic                  beat_accept;
  logic                  hdr_load;
  beat_t                 cur_beat;

  rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Granted source's current beat
  assign cur_beat.last = s_axis_tlast[grant_id];
  assign cur_beat.data = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];

  assign slot_free     = ~out_valid | m_axis_tready;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_any) begin
`ifdef UART_ARB_HEADER_EN
          state_next = HDR;
`else
          state_next = STREAM;
`endif
        end
      end
      HDR: begin
`ifdef UART_ARB_HEADER_EN
        if (slot_free) state_next = STREAM;
`else
        state_next = STREAM;
`endif
      end
      STREAM: begin
        if (beat_accept && cur_beat.last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs: only the granted source sees ready, and only in STREAM
  always_comb begin
    s_axis_tready = '0;
    beat_accept   = 1'b0;
    hdr_load      = 1'b0;
    case (state)
      STREAM: begin
        s_axis_tready[grant_id] = slot_free;
        beat_accept             = slot_free & s_axis_tvalid[grant_id];
      end
      HDR: begin
`ifdef UART_ARB_HEADER_EN
        hdr_load = slot_free;
`endif
      end
      default: ;
    endcase
  end

  // Output slot, grant bookkeeping and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (beat_accept) begin
        out_valid <= 1'b1;
        out_data  <= cur_beat.data;
      end else if (hdr_load) begin
        out_valid <= 1'b1;
        out_data  <= DATA_WIDTH'(hdr_byte(4'(grant_id)));
      end else if (m_axis_tready) begin
        out_valid <= 1'b0;
      end

      if (state == IDLE && pick_any) begin
        grant_id <= pick_idx;
        busy     <= 1'b1;
      end

      if (beat_accept && cur_beat.last) begin
        busy   <= 1'b0;
        rr_ptr <= (grant_id == IDX_W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule
